darkbus_arbiter: RTL and testbench

- Shares one darkbus consumer, such as a RAM or IO bank, among NMST providers, such as core I-port, core D-port and a DMA/debug master.
- Grants one transaction at a time using round-robin or fixed priority.
- Routes the granted provider's request to the consumer and returns RACK/WACK and read data to that provider only.
- A watchdog completes any transaction the consumer never acknowledges, so a dead slave cannot lock the bus.
- Sits between the provider modports and a single consumer modport. Inout DATA is split into WDATA/RDATA here; tristate resolution is done at the interface binding outside this block.

---
 rtl/darkbus_pkg.sv | 23 ++
 rtl/darkbus_rr_pick.sv | 49 ++++
 rtl/darkbus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_darkbus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkbus_pkg.sv
// ---------------------------------------------------------------------------
// darkbus_pkg
// Shared types and constants for the darkbus arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE waits for requests, BUSY owns the
//                 consumer on behalf of one provider)
//   TOUT_RDATA  : read data returned to a provider when the watchdog has to
//                 complete a read that the consumer never acknowledged
//   DB_AW/DB_DW/DB_BEW : darkbus address, data and byte-enable widths
//   WDOG_W      : width of the watchdog counter (covers TOUT_CYC up to 65535)
// ---------------------------------------------------------------------------
package darkbus_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam logic [31:0] TOUT_RDATA = 32'hFFFF_FFFF;

    localparam int DB_AW  = 32;
    localparam int DB_DW  = 32;
    localparam int DB_BEW = 4;

    localparam int WDOG_W = 16;

endpackage

// File: rtl/darkbus_rr_pick.sv
// ---------------------------------------------------------------------------
// darkbus_rr_pick
// Purely combinational winner selection for the darkbus arbiter.
// Ports:
//   req   [NMST]  : request vector, one bit per provider
//   ptr   [IW]    : round-robin start position (index that has top priority)
//   fixed         : 1 = ignore ptr and let the lowest requesting index win
//   gnt   [NMST]  : one-hot winner, all zero when nothing is requested
//   idx   [IW]    : binary index of the winner (0 when nothing is requested)
// ---------------------------------------------------------------------------
module darkbus_rr_pick #(
    parameter int NMST = 2,
    parameter int IW   = $clog2(NMST)
) (
    input  logic [NMST-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            fixed,
    output logic [NMST-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic          hi_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // The round-robin search is split in two halves instead of rotating the
    // request vector: the lowest requester at or above ptr wins if there is
    // one, otherwise the search wraps and the lowest requester overall wins.
    // Scanning downwards means the last hit in each half is the lowest index.
    // In fixed mode every requester counts as "at or above ptr", so the
    // lowest index always wins.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NMST - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                if (fixed || (i >= int'(ptr))) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        idx = hi_found ? hi_idx : lo_idx;
        gnt = (|req) ? (NMST'(1) << idx) : '0;
    end

endmodule

// File: rtl/darkbus_arbiter.sv
// ---------------------------------------------------------------------------
// darkbus_arbiter
// Shares one darkbus consumer among NMST providers. One transaction at a
// time is granted (round-robin or fixed priority), the granted provider's
// request is routed to the consumer and the consumer's acks / read data are
// routed back to that provider only. A watchdog completes any transaction the
// consumer never acknowledges so a dead slave cannot lock the bus.
// Parameters:
//   NMST       : number of providers (2..8)
//   FIXED_PRIO : 0 = round-robin, 1 = fixed priority (lowest index wins)
//   TOUT_CYC   : BUSY cycles without an ack before forced completion
// Ports:
//   clk, res_n                 : clock (rising edge), async active-low reset
//   m_en/m_re/m_we [NMST]      : per-provider request enable / read / write
//   m_be   [4*NMST]            : per-provider byte enables, provider i at [4i+3:4i]
//   m_addr/m_wdata [32*NMST]   : per-provider address / write data
//   m_rdata [32*NMST]          : per-provider read data (0 unless granted)
//   m_rack/m_wack [NMST]       : per-provider read / write ack pulses
//   s_en/s_re/s_we, s_be, s_addr, s_wdata : request towards the consumer
//   s_rdata, s_rack, s_wack    : consumer read data and ack pulses
//   gnt [NMST]                 : registered one-hot grant, zero when idle
//   tout                       : one-cycle pulse when the watchdog completes
// ---------------------------------------------------------------------------
module darkbus_arbiter
    import darkbus_pkg::*;
#(
    parameter int NMST       = 2,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TOUT_CYC   = 255
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic [NMST-1:0]         m_en,
    input  logic [NMST-1:0]         m_re,
    input  logic [NMST-1:0]         m_we,
    input  logic [DB_BEW*NMST-1:0]  m_be,
    input  logic [DB_AW*NMST-1:0]   m_addr,
    input  logic [DB_DW*NMST-1:0]   m_wdata,
    output logic [DB_DW*NMST-1:0]   m_rdata,
    output logic [NMST-1:0]         m_rack,
    output logic [NMST-1:0]         m_wack,
    output logic                    s_en,
    output logic                    s_re,
    output logic                    s_we,
    output logic [DB_BEW-1:0]       s_be,
    output logic [DB_AW-1:0]        s_addr,
    output logic [DB_DW-1:0]        s_wdata,
    input  logic [DB_DW-1:0]        s_rdata,
    input  logic                    s_rack,
    input  logic                    s_wack,
    output logic [NMST-1:0]         gnt,
    output logic                    tout
);

    localparam int IW = $clog2(NMST);

    // The counter is compared against TOUT_CYC-1 because it starts at 0 on
    // the first BUSY cycle: the TOUT_CYC-th BUSY cycle is the expiry cycle.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    logic [NMST-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic [NMST-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;

    logic              ack_in;
    logic              expire;
    logic              timeout;
    logic [IW-1:0]     ptr_inc;

    darkbus_rr_pick #(
        .NMST (NMST),
        .IW   (IW)
    ) u_pick (
        .req   (m_en),
        .ptr   (ptr_q),
        .fixed (FIXED_PRIO),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    assign gnt = gnt_q;

    // State register. Everything the routing muxes depend on lives here, so
    // an asynchronous reset immediately returns all outputs to zero and drops
    // s_en in the middle of a transaction without producing an ack.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state and output logic. In IDLE the picker result is registered
    // as the grant; nothing is routed, so consumer acks arriving in IDLE are
    // simply dropped. In BUSY the registered grant index selects which
    // provider drives the consumer and which provider sees acks/read data.
    // A transaction ends on a real ack, on the provider dropping its enable
    // (abort, no ack), or on watchdog expiry. A real ack in the expiry cycle
    // takes precedence, and an aborting provider gets no forced ack either.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;

        s_en    = 1'b0;
        s_re    = 1'b0;
        s_we    = 1'b0;
        s_be    = '0;
        s_addr  = '0;
        s_wdata = '0;
        m_rdata = '0;
        m_rack  = '0;
        m_wack  = '0;
        tout    = 1'b0;

        ack_in  = s_rack | s_wack;
        expire  = (wdog_q == WDOG_LAST);
        timeout = 1'b0;
        ptr_inc = (gidx_q == IW'(NMST - 1)) ? '0 : gidx_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|m_en) begin
                    state_d = BUSY;
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    wdog_d  = '0;
                end else begin
                    gnt_d   = '0;
                end
            end

            BUSY: begin
                timeout = expire && m_en[gidx_q] && !ack_in;

                s_en    = m_en[gidx_q] && !timeout;
                s_re    = m_re[gidx_q];
                s_we    = m_we[gidx_q];
                s_be    = m_be[gidx_q*DB_BEW +: DB_BEW];
                s_addr  = m_addr[gidx_q*DB_AW +: DB_AW];
                s_wdata = m_wdata[gidx_q*DB_DW +: DB_DW];

                m_rack[gidx_q] = s_rack | (timeout & m_re[gidx_q]);
                m_wack[gidx_q] = s_wack | (timeout & ~m_re[gidx_q]);
                m_rdata[gidx_q*DB_DW +: DB_DW] = timeout ? TOUT_RDATA : s_rdata;
                tout = timeout;

                if (ack_in || !m_en[gidx_q] || timeout) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    wdog_d  = '0;
                    if (!FIXED_PRIO) begin
                        ptr_d = ptr_inc;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_darkbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_darkbus_arbiter
// Directed bench for darkbus_arbiter with NMST = 2 and TOUT_CYC = 4. Two
// instances share the same stimulus: a round-robin one (rr_*) checked by the
// vector table and hand sequences, and a fixed-priority one (fx_*) checked in
// the fixed-priority sequence. The consumer is modelled by the stimulus
// itself: acks and read data are placed in fixed cycles by the vectors.
// ---------------------------------------------------------------------------
module tb_darkbus_arbiter;

    localparam int NMST = 2;

    localparam logic [31:0] ADDR0 = 32'h0000_0100;
    localparam logic [31:0] ADDR1 = 32'h0000_0200;
    localparam logic [3:0]  BE0   = 4'hF;
    localparam logic [3:0]  BE1   = 4'h3;
    localparam logic [31:0] WD0   = 32'hA0A0_A0A0;
    localparam logic [31:0] WD1   = 32'hB1B1_B1B1;

    logic clk = 1'b0;
    logic res_n;

    logic [NMST-1:0]    m_en, m_re, m_we;
    logic [4*NMST-1:0]  m_be;
    logic [32*NMST-1:0] m_addr, m_wdata;
    logic               s_rack, s_wack;
    logic [31:0]        s_rdata;

    logic [32*NMST-1:0] rr_m_rdata, fx_m_rdata;
    logic [NMST-1:0]    rr_m_rack, rr_m_wack, fx_m_rack, fx_m_wack;
    logic               rr_s_en, rr_s_re, rr_s_we, fx_s_en, fx_s_re, fx_s_we;
    logic [3:0]         rr_s_be, fx_s_be;
    logic [31:0]        rr_s_addr, rr_s_wdata, fx_s_addr, fx_s_wdata;
    logic [NMST-1:0]    rr_gnt, fx_gnt;
    logic               rr_tout, fx_tout;

    int nApplied    = 0;
    int nMiscompares = 0;

    typedef struct {
        logic [1:0]  en, re, we;
        logic        srack, swack;
        logic [31:0] srdata;
        logic [1:0]  egnt;
        logic        esen;
        logic [1:0]  ectl;
        logic [3:0]  ebe;
        logic [31:0] eaddr, ewd;
        logic [1:0]  erack, ewack;
        logic        etout;
        logic [31:0] erd0, erd1;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    darkbus_arbiter #(.NMST(NMST), .FIXED_PRIO(1'b0), .TOUT_CYC(4)) u_rr (
        .clk(clk), .res_n(res_n),
        .m_en(m_en), .m_re(m_re), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(rr_m_rdata),
        .m_rack(rr_m_rack), .m_wack(rr_m_wack),
        .s_en(rr_s_en), .s_re(rr_s_re), .s_we(rr_s_we), .s_be(rr_s_be),
        .s_addr(rr_s_addr), .s_wdata(rr_s_wdata), .s_rdata(s_rdata),
        .s_rack(s_rack), .s_wack(s_wack), .gnt(rr_gnt), .tout(rr_tout)
    );

    darkbus_arbiter #(.NMST(NMST), .FIXED_PRIO(1'b1), .TOUT_CYC(4)) u_fx (
        .clk(clk), .res_n(res_n),
        .m_en(m_en), .m_re(m_re), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(fx_m_rdata),
        .m_rack(fx_m_rack), .m_wack(fx_m_wack),
        .s_en(fx_s_en), .s_re(fx_s_re), .s_we(fx_s_we), .s_be(fx_s_be),
        .s_addr(fx_s_addr), .s_wdata(fx_s_wdata), .s_rdata(s_rdata),
        .s_rack(s_rack), .s_wack(s_wack), .gnt(fx_gnt), .tout(fx_tout)
    );

    // Every comparison funnels through here so the miscompare count and the
    // report format stay in one place.
    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL step %0d %s: got %h, expected %h", step, name, act, exp);
        end
    endtask

    // Build one table record; the expected consumer-side routing follows from
    // which provider the record says should be granted.
    task automatic addVec(input logic [1:0] en, input logic [1:0] re, input logic [1:0] we,
                          input logic srack, input logic swack, input logic [31:0] srdata,
                          input logic [1:0] egnt, input logic esen,
                          input logic [1:0] erack, input logic [1:0] ewack,
                          input logic etout, input logic [31:0] erd0, input logic [31:0] erd1);
        vec_t v;
        v.en = en; v.re = re; v.we = we;
        v.srack = srack; v.swack = swack; v.srdata = srdata;
        v.egnt = egnt; v.esen = esen;
        v.erack = erack; v.ewack = ewack; v.etout = etout;
        v.erd0 = erd0; v.erd1 = erd1;
        if (egnt == 2'b01) begin
            v.ectl = {re[0], we[0]}; v.ebe = BE0; v.eaddr = ADDR0; v.ewd = WD0;
        end else if (egnt == 2'b10) begin
            v.ectl = {re[1], we[1]}; v.ebe = BE1; v.eaddr = ADDR1; v.ewd = WD1;
        end else begin
            v.ectl = 2'b00; v.ebe = 4'h0; v.eaddr = 32'h0; v.ewd = 32'h0;
        end
        vecs.push_back(v);
    endtask

    task automatic setIn(input logic [1:0] en, input logic [1:0] re, input logic [1:0] we,
                         input logic srack, input logic swack, input logic [31:0] srdata);
        m_en = en; m_re = re; m_we = we;
        s_rack = srack; s_wack = swack; s_rdata = srdata;
    endtask

    // Drive one table record half a cycle before the next rising edge and
    // compare the round-robin instance's outputs shortly afterwards.
    task automatic applyStimulus(input vec_t v, input int step);
        @(negedge clk);
        setIn(v.en, v.re, v.we, v.srack, v.swack, v.srdata);
        #1;
        nApplied++;
        checkOutput("gnt",    step, 32'(rr_gnt),                v.egnt);
        checkOutput("s_en",   step, 32'(rr_s_en),               v.esen);
        checkOutput("s_re_we",step, 32'({rr_s_re, rr_s_we}),    v.ectl);
        checkOutput("s_be",   step, 32'(rr_s_be),               v.ebe);
        checkOutput("s_addr", step, rr_s_addr,                  v.eaddr);
        checkOutput("s_wdata",step, rr_s_wdata,                 v.ewd);
        checkOutput("m_rack", step, 32'(rr_m_rack),             v.erack);
        checkOutput("m_wack", step, 32'(rr_m_wack),             v.ewack);
        checkOutput("tout",   step, 32'(rr_tout),               v.etout);
        checkOutput("m_rdata0", step, rr_m_rdata[31:0],         v.erd0);
        checkOutput("m_rdata1", step, rr_m_rdata[63:32],        v.erd1);
    endtask

    // Reset both instances with quiet inputs and confirm the reset state.
    task automatic doReset(input int step);
        @(negedge clk);
        res_n = 1'b0;
        setIn(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        nApplied++;
        checkOutput("rst gnt",    step, 32'(rr_gnt),     32'h0);
        checkOutput("rst s_en",   step, 32'(rr_s_en),    32'h0);
        checkOutput("rst s_addr", step, rr_s_addr,       32'h0);
        checkOutput("rst acks",   step, 32'({rr_m_rack, rr_m_wack}), 32'h0);
        checkOutput("rst tout",   step, 32'(rr_tout),    32'h0);
        checkOutput("rst fx gnt", step, 32'(fx_gnt),     32'h0);
        repeat (2) @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        res_n   = 1'b0;
        m_be    = {BE1, BE0};
        m_addr  = {ADDR1, ADDR0};
        m_wdata = {WD1, WD0};
        setIn(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);

        // Contention: both providers write continuously and the consumer ack
        // is held high, so every BUSY cycle completes immediately and IDLE
        // cycles show that stray acks are ignored. Expected order 0,1,0,1.
        for (int k = 0; k < 2; k++) begin
            addVec(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 32'h5A5A5A5A, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
            addVec(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 32'h5A5A5A5A, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 32'h5A5A5A5A, 32'h0);
            addVec(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 32'h5A5A5A5A, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
            addVec(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 32'h5A5A5A5A, 2'b10, 1'b1, 2'b00, 2'b10, 1'b0, 32'h0, 32'h5A5A5A5A);
        end
        addVec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Single read from provider 0, consumer acks two cycles after s_en.
        addVec(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h12345678, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 32'h12345678, 32'h0);
        addVec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Watchdog: provider 1 read never acked, forced completion on the
        // fourth BUSY cycle with s_en low and all-ones read data.
        addVec(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++)
            addVec(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 2'b10, 2'b00, 1'b1, 32'h0, 32'hFFFFFFFF);
        addVec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Real ack lands exactly on the expiry cycle: real data, no tout.
        addVec(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++)
            addVec(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'hCAFEF00D, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 32'hCAFEF00D, 32'h0);
        addVec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        // Abort: provider 1 drops its enable mid-write, no ack is issued and
        // the pointer still advances, so provider 0 wins the next contention.
        addVec(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'h77777777, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 32'h77777777, 32'h0);
        addVec(2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        addVec(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'h88888888, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 32'h0, 32'h88888888);
        addVec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);

        $display("[TB] table test: %0d vectors", vecs.size());
        doReset(0);
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i + 1);

        // Fixed priority: both providers write for four transactions; the
        // fixed instance grants provider 0 every time, provider 1 never acks.
        $display("[TB] fixed priority sequence");
        doReset(100);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            setIn(2'b11, 2'b00, 2'b11, 1'b0, 1'b1, 32'h0);
            #1;
            nApplied++;
            checkOutput("fx gnt",  200 + k, 32'(fx_gnt),    (k % 2 == 1) ? 32'h1 : 32'h0);
            checkOutput("fx wack", 200 + k, 32'(fx_m_wack), (k % 2 == 1) ? 32'h1 : 32'h0);
            checkOutput("fx s_en", 200 + k, 32'(fx_s_en),   (k % 2 == 1) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of a provider 1 transaction, with the pointer
        // previously moved to 1, then normal arbitration from pointer 0.
        $display("[TB] reset mid-transaction sequence");
        doReset(300);
        @(negedge clk);
        setIn(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        setIn(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h11111111);
        #1;
        nApplied++;
        checkOutput("pre rack", 301, 32'(rr_m_rack), 32'h1);
        @(negedge clk);
        setIn(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        nApplied++;
        checkOutput("busy s_en", 302, 32'(rr_s_en), 32'h1);
        checkOutput("busy gnt",  302, 32'(rr_gnt),  32'h2);
        #1;
        res_n = 1'b0;
        #1;
        nApplied++;
        checkOutput("async s_en",   303, 32'(rr_s_en),   32'h0);
        checkOutput("async gnt",    303, 32'(rr_gnt),    32'h0);
        checkOutput("async s_addr", 303, rr_s_addr,      32'h0);
        checkOutput("async acks",   303, 32'({rr_m_rack, rr_m_wack}), 32'h0);
        @(negedge clk);
        setIn(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'hDEADDEAD);
        #1;
        nApplied++;
        checkOutput("held rack",  304, 32'(rr_m_rack),        32'h0);
        checkOutput("held rdata", 304, rr_m_rdata[63:32],     32'h0);
        @(negedge clk);
        res_n = 1'b1;
        setIn(2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        nApplied++;
        checkOutput("post gnt idle", 305, 32'(rr_gnt), 32'h0);
        @(negedge clk);
        setIn(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'h22222222);
        #1;
        nApplied++;
        checkOutput("post gnt0",  306, 32'(rr_gnt),          32'h1);
        checkOutput("post rack0", 306, 32'(rr_m_rack),       32'h1);
        checkOutput("post rd0",   306, rr_m_rdata[31:0],     32'h22222222);
        @(negedge clk);
        setIn(2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        setIn(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'h33333333);
        #1;
        nApplied++;
        checkOutput("post gnt1",  307, 32'(rr_gnt),          32'h2);
        checkOutput("post rack1", 307, 32'(rr_m_rack),       32'h2);
        checkOutput("post rd1",   307, rr_m_rdata[63:32],    32'h33333333);
        checkOutput("post rd0 z", 307, rr_m_rdata[31:0],     32'h0);
        @(negedge clk);
        setIn(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
